// File: rtl/exmem_pipeline_reg.sv
// EX/MEM pipeline register: holds one EX-stage result for the MEM stage,
// supports stall (hold) and flush (bubble), decodes valid-gated MEM control
// fields, drives a forwarding tap and keeps saturating stall/bubble counters.
module exmem_pipeline_reg #(
  parameter int CTRL_W      = 22,
  parameter int DATA_W      = 32,
  parameter int RD_W        = 5,
  parameter int CNT_W       = 16,
  parameter int POS_MEM_EN  = 0,
  parameter int POS_SE      = 3,
  parameter int POS_RW      = 4,
  parameter int POS_SIZE_LO = 5,
  parameter int POS_RF_EN   = 9,
  parameter int POS_LOAD    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clear,
  input  logic              ex_valid,
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic [DATA_W-1:0] ex_pa,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_pc8,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_r31,
  output logic              mem_valid,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [DATA_W-1:0] mem_pa,
  output logic [DATA_W-1:0] mem_alu,
  output logic [DATA_W-1:0] mem_pc8,
  output logic [RD_W-1:0]   mem_rd,
  output logic              mem_r31,
  output logic [1:0]        mem_size,
  output logic              mem_se,
  output logic              mem_rw,
  output logic              mem_enable,
  output logic              mem_load,
  output logic              mem_rf_enable,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic stall_inc;
  logic bubble_inc;

  // A stall only counts while it actually holds a live entry; a bubble is any
  // edge that leaves an invalid entry behind.
  assign stall_inc  = stall & ~flush & mem_valid;
  assign bubble_inc = flush | (~stall & ~ex_valid);

  // Pipeline registers: reset > flush > stall > load. Flush only kills valid
  // and control; the data fields are don't-care once the entry is invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
      mem_pa    <= '0;
      mem_alu   <= '0;
      mem_pc8   <= '0;
      mem_rd    <= '0;
      mem_r31   <= 1'b0;
    end else if (flush) begin
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
    end else if (!stall) begin
      mem_valid <= ex_valid;
      mem_ctrl  <= ex_valid ? ex_ctrl : '0;
      mem_pa    <= ex_pa;
      mem_alu   <= ex_alu;
      mem_pc8   <= ex_pc8;
      mem_rd    <= ex_rd;
      mem_r31   <= ex_r31;
    end
  end

  // Saturating stall counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Saturating bubble counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      bubble_cnt <= '0;
    end else if (bubble_inc && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  // Decoded MEM control, forced inactive for an invalid entry.
  assign mem_size      = mem_valid ? mem_ctrl[POS_SIZE_LO+1:POS_SIZE_LO] : 2'b00;
  assign mem_se        = mem_valid & mem_ctrl[POS_SE];
  assign mem_rw        = mem_valid & mem_ctrl[POS_RW];
  assign mem_enable    = mem_valid & mem_ctrl[POS_MEM_EN];
  assign mem_load      = mem_valid & mem_ctrl[POS_LOAD];
  assign mem_rf_enable = mem_valid & mem_ctrl[POS_RF_EN];

  // Forwarding tap: loads are excluded because their data only exists after MEM.
  assign fwd_valid = mem_valid & mem_rf_enable & ~mem_load;
  assign fwd_rd    = mem_rd;
  assign fwd_data  = mem_r31 ? mem_pc8 : mem_alu;

endmodule

// File: tb/tb_exmem_pipeline_reg.sv
// Bench for exmem_pipeline_reg: directed scenarios plus randomized traffic
// checked against a transaction-level model. A second instance with 4-bit
// counters shares all inputs and is used for saturation checks.
module tb_exmem_pipeline_reg;
  localparam int CTRL_W = 22;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  logic              clk = 1'b0;
  logic              reset, stall, flush, cnt_clear, ex_valid, ex_r31;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_pa, ex_alu, ex_pc8;
  logic [RD_W-1:0]   ex_rd;

  logic              mem_valid, mem_r31, mem_se, mem_rw, mem_enable, mem_load, mem_rf_enable, fwd_valid;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [DATA_W-1:0] mem_pa, mem_alu, mem_pc8, fwd_data;
  logic [RD_W-1:0]   mem_rd, fwd_rd;
  logic [1:0]        mem_size;
  logic [15:0]       stall_cnt, bubble_cnt;

  logic              s_mem_valid, s_mem_r31, s_mem_se, s_mem_rw, s_mem_enable, s_mem_load, s_mem_rf_enable, s_fwd_valid;
  logic [CTRL_W-1:0] s_mem_ctrl;
  logic [DATA_W-1:0] s_mem_pa, s_mem_alu, s_mem_pc8, s_fwd_data;
  logic [RD_W-1:0]   s_mem_rd, s_fwd_rd;
  logic [1:0]        s_mem_size;
  logic [3:0]        s_stall_cnt, s_bubble_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: one pipeline entry plus event counts
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_pa, m_alu, m_pc8;
  logic [RD_W-1:0]   m_rd;
  logic              m_r31;
  int                n_stall, n_bubble;

  exmem_pipeline_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clear(cnt_clear),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pa(ex_pa), .ex_alu(ex_alu), .ex_pc8(ex_pc8),
    .ex_rd(ex_rd), .ex_r31(ex_r31),
    .mem_valid(mem_valid), .mem_ctrl(mem_ctrl), .mem_pa(mem_pa), .mem_alu(mem_alu), .mem_pc8(mem_pc8),
    .mem_rd(mem_rd), .mem_r31(mem_r31), .mem_size(mem_size), .mem_se(mem_se), .mem_rw(mem_rw),
    .mem_enable(mem_enable), .mem_load(mem_load), .mem_rf_enable(mem_rf_enable),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  exmem_pipeline_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clear(cnt_clear),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pa(ex_pa), .ex_alu(ex_alu), .ex_pc8(ex_pc8),
    .ex_rd(ex_rd), .ex_r31(ex_r31),
    .mem_valid(s_mem_valid), .mem_ctrl(s_mem_ctrl), .mem_pa(s_mem_pa), .mem_alu(s_mem_alu), .mem_pc8(s_mem_pc8),
    .mem_rd(s_mem_rd), .mem_r31(s_mem_r31), .mem_size(s_mem_size), .mem_se(s_mem_se), .mem_rw(s_mem_rw),
    .mem_enable(s_mem_enable), .mem_load(s_mem_load), .mem_rf_enable(s_mem_rf_enable),
    .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data),
    .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // One clock edge: advance the model with the inputs the DUT samples, then settle.
  task automatic tick();
    bit live_stall, bubble;
    @(posedge clk);
    live_stall = stall && !flush && m_valid;
    bubble     = flush || (!stall && !ex_valid);
    if (reset) begin
      m_valid = 0; m_ctrl = '0; m_pa = '0; m_alu = '0; m_pc8 = '0; m_rd = '0; m_r31 = 0;
      n_stall = 0; n_bubble = 0;
    end else begin
      if (flush) begin
        m_valid = 0; m_ctrl = '0;
      end else if (!stall) begin
        m_valid = ex_valid;
        m_ctrl  = ex_valid ? ex_ctrl : '0;
        m_pa = ex_pa; m_alu = ex_alu; m_pc8 = ex_pc8; m_rd = ex_rd; m_r31 = ex_r31;
      end
      if (cnt_clear) begin
        n_stall = 0; n_bubble = 0;
      end else begin
        n_stall  += int'(live_stall);
        n_bubble += int'(bubble);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0; cnt_clear = 0; ex_valid = 0; ex_r31 = 0;
    ex_ctrl = '0; ex_pa = '0; ex_alu = '0; ex_pc8 = '0; ex_rd = '0;
  endtask

  task automatic test_reset();
    reset = 1; stall = 1; flush = 1; cnt_clear = 1; ex_valid = 1; ex_r31 = 1;
    ex_ctrl = '1; ex_pa = '1; ex_alu = '1; ex_pc8 = '1; ex_rd = '1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({mem_valid, mem_ctrl, mem_pa, mem_alu, mem_pc8, mem_rd, mem_r31} !== '0) begin
        errors++; $display("FAIL reset_regs cycle %0d: got nonzero registers", i);
      end
      checks++;
      if ({mem_size, mem_se, mem_rw, mem_enable, mem_load, mem_rf_enable} !== 6'b0) begin
        errors++; $display("FAIL reset_decode cycle %0d: got %b expected 0", i,
                           {mem_size, mem_se, mem_rw, mem_enable, mem_load, mem_rf_enable});
      end
      checks++;
      if ({fwd_valid, fwd_rd, fwd_data} !== '0 || stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
        errors++; $display("FAIL reset_fwd_cnt cycle %0d: fwd_valid=%b fwd_data=%h stall=%0d bubble=%0d",
                           i, fwd_valid, fwd_data, stall_cnt, bubble_cnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_pass_through();
    ex_valid = 1; ex_ctrl = 22'h000661; ex_alu = 32'h0000_1234; ex_rd = 5'd7;
    tick();
    checks++;
    if ({mem_valid, mem_enable, mem_size, mem_load, mem_rd, fwd_valid} !== {1'b1, 1'b1, 2'b11, 1'b1, 5'd7, 1'b0}) begin
      errors++; $display("FAIL pass_through: valid=%b en=%b size=%b load=%b rd=%0d fwd_valid=%b",
                         mem_valid, mem_enable, mem_size, mem_load, mem_rd, fwd_valid);
    end
    checks++;
    if (mem_alu !== 32'h0000_1234 || mem_ctrl !== 22'h000661) begin
      errors++; $display("FAIL pass_through_data: alu=%h ctrl=%h", mem_alu, mem_ctrl);
    end
    idle_inputs();
  endtask

  task automatic test_stall_hold();
    ex_valid = 1; ex_ctrl = 22'h000200; ex_alu = 32'hAAAA_0001; cnt_clear = 1;
    tick();
    cnt_clear = 0; stall = 1;
    for (int i = 0; i < 3; i++) begin
      ex_alu = $urandom; ex_rd = 5'($urandom); ex_valid = 1'($urandom);
      tick();
      checks++;
      if (mem_alu !== 32'hAAAA_0001 || mem_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold cycle %0d: alu=%h valid=%b expected AAAA0001/1", i, mem_alu, mem_valid);
      end
    end
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++; $display("FAIL stall_count: got %0d expected 3", stall_cnt);
    end
    stall = 0; ex_valid = 1; ex_alu = 32'h5555_0002;
    tick();
    checks++;
    if (mem_alu !== 32'h5555_0002) begin
      errors++; $display("FAIL stall_release: got %h expected 55550002", mem_alu);
    end
    idle_inputs();
  endtask

  task automatic test_flush_with_stall();
    ex_valid = 1; ex_ctrl = 22'h000200; ex_alu = 32'h1111_2222; cnt_clear = 1;
    tick();
    cnt_clear = 0; flush = 1; stall = 1;
    tick();
    checks++;
    if ({mem_valid, mem_rf_enable, fwd_valid} !== 3'b000) begin
      errors++; $display("FAIL flush_stall_kill: valid=%b rf_en=%b fwd_valid=%b", mem_valid, mem_rf_enable, fwd_valid);
    end
    checks++;
    if (bubble_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL flush_stall_cnt: bubble=%0d stall=%0d expected 1/0", bubble_cnt, stall_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_r31_forward();
    ex_valid = 1; ex_ctrl = 22'h000200; ex_r31 = 1; ex_pc8 = 32'h0040_0008; ex_alu = 32'hDEAD_BEEF; ex_rd = 5'd31;
    tick();
    checks++;
    if (fwd_data !== 32'h0040_0008 || fwd_valid !== 1'b1 || fwd_rd !== 5'd31) begin
      errors++; $display("FAIL r31_forward: data=%h valid=%b rd=%0d", fwd_data, fwd_valid, fwd_rd);
    end
    ex_r31 = 0; ex_alu = 32'h0BAD_F00D;
    tick();
    checks++;
    if (fwd_data !== 32'h0BAD_F00D || fwd_valid !== 1'b1) begin
      errors++; $display("FAIL alu_forward: data=%h valid=%b expected 0BADF00D/1", fwd_data, fwd_valid);
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    ex_valid = 1; ex_ctrl = 22'h000200; cnt_clear = 1;
    tick();
    cnt_clear = 0; stall = 1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (s_stall_cnt !== 4'hF || stall_cnt !== 16'd20) begin
      errors++; $display("FAIL stall_saturation: small=%h wide=%0d expected F/20", s_stall_cnt, stall_cnt);
    end
    cnt_clear = 1;
    tick();
    checks++;
    if (s_stall_cnt !== 4'h0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL clear_over_stall: small=%h wide=%0d expected 0", s_stall_cnt, stall_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_stall();
    ex_valid = 1; ex_ctrl = 22'h000219; ex_alu = 32'h7777_0000;
    tick();
    stall = 1; flush = 1; reset = 1;
    tick();
    checks++;
    if ({mem_valid, mem_ctrl, mem_alu, stall_cnt, bubble_cnt, fwd_data} !== '0) begin
      errors++; $display("FAIL reset_in_stall: valid=%b ctrl=%h alu=%h", mem_valid, mem_ctrl, mem_alu);
    end
    reset = 0; stall = 0; flush = 0; ex_alu = 32'h7777_0001;
    tick();
    checks++;
    if (mem_valid !== 1'b1 || mem_alu !== 32'h7777_0001 || mem_ctrl !== 22'h000219) begin
      errors++; $display("FAIL post_reset_load: valid=%b alu=%h ctrl=%h", mem_valid, mem_alu, mem_ctrl);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int sat16, sat4s, sat4b;
    logic [1:0] e_size;
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      cnt_clear = ($urandom_range(0, 99) == 0);
      ex_valid  = ($urandom_range(0, 3) != 0);
      ex_r31    = 1'($urandom);
      ex_ctrl   = CTRL_W'($urandom);
      ex_pa = $urandom; ex_alu = $urandom; ex_pc8 = $urandom; ex_rd = RD_W'($urandom);
      tick();
      checks++;
      if ({mem_valid, mem_ctrl, mem_rd, mem_r31, mem_pa, mem_alu, mem_pc8} !==
          {m_valid, m_ctrl, m_rd, m_r31, m_pa, m_alu, m_pc8}) begin
        errors++; $display("FAIL rand_regs %0d: valid=%b/%b ctrl=%h/%h alu=%h/%h", i,
                           mem_valid, m_valid, mem_ctrl, m_ctrl, mem_alu, m_alu);
      end
      e_size = m_valid ? {m_ctrl[6], m_ctrl[5]} : 2'b00;
      checks++;
      if ({mem_size, mem_se, mem_rw, mem_enable, mem_load, mem_rf_enable} !==
          {e_size, m_valid & m_ctrl[3], m_valid & m_ctrl[4], m_valid & m_ctrl[0], m_valid & m_ctrl[10], m_valid & m_ctrl[9]}) begin
        errors++; $display("FAIL rand_decode %0d: got %b", i, {mem_size, mem_se, mem_rw, mem_enable, mem_load, mem_rf_enable});
      end
      checks++;
      if ({fwd_valid, fwd_rd, fwd_data} !== {m_valid & m_ctrl[9] & ~m_ctrl[10], m_rd, (m_r31 ? m_pc8 : m_alu)}) begin
        errors++; $display("FAIL rand_fwd %0d: valid=%b rd=%0d data=%h", i, fwd_valid, fwd_rd, fwd_data);
      end
      sat16 = (n_stall > 65535) ? 65535 : n_stall;
      sat4s = (n_stall > 15) ? 15 : n_stall;
      sat4b = (n_bubble > 15) ? 15 : n_bubble;
      checks++;
      if (int'(stall_cnt) != sat16 || int'(bubble_cnt) != ((n_bubble > 65535) ? 65535 : n_bubble) ||
          int'(s_stall_cnt) != sat4s || int'(s_bubble_cnt) != sat4b) begin
        errors++; $display("FAIL rand_cnt %0d: stall=%0d/%0d bubble=%0d/%0d small=%0d,%0d exp %0d,%0d", i,
                           stall_cnt, sat16, bubble_cnt, n_bubble, s_stall_cnt, s_bubble_cnt, sat4s, sat4b);
      end
    end
    idle_inputs();
  endtask

  initial begin
    m_valid = 0; m_ctrl = '0; m_pa = '0; m_alu = '0; m_pc8 = '0; m_rd = '0; m_r31 = 0;
    n_stall = 0; n_bubble = 0;
    idle_inputs();
    #1;
    test_reset();
    test_pass_through();
    test_stall_hold();
    test_flush_with_stall();
    test_r31_forward();
    test_saturation();
    test_reset_in_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exmem_pipeline_reg.md
# exmem_pipeline_reg

Parametrised EX/MEM pipeline register with valid tracking, stall (hold) and flush (bubble insertion). It sits between the EX and MEM stages of the CPU pipeline. It also does the following:
- decodes the MEM-stage control fields, gated by valid;
- exports a forwarding tap for the EX-stage hazard unit;
- keeps saturating stall and bubble counters for performance monitoring.

## Interface
Parameters:
- CTRL_W, 22, control-bus width
- DATA_W, 32, width of PA, ALU and PC8 data paths
- RD_W, 5, destination-register index width
- CNT_W, 16, performance-counter width
- Control-bit positions (defaults):
  - POS_MEM_EN, 0
  - POS_SE, 3
  - POS_RW, 4
  - POS_SIZE_LO, 5 (size field is POS_SIZE_LO+1:POS_SIZE_LO)
  - POS_RF_EN, 9
  - POS_LOAD, 10

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- stall  in  1  hold the current contents
- flush  in  1  load a bubble
- cnt_clear  in  1  synchronous clear of both counters
- ex_valid  in  1  EX stage holds a real instruction
- ex_ctrl  in  CTRL_W  EX control bus
- ex_pa, ex_alu, ex_pc8  in  DATA_W  EX data
- ex_rd  in  RD_W  destination register
- ex_r31  in  1  link-to-R31 (PC8 write-back select)
- mem_valid  out  1  registered valid
- mem_ctrl  out  CTRL_W  registered control bus (raw)
- mem_pa, mem_alu, mem_pc8  out  DATA_W  registered data
- mem_rd  out  RD_W  registered destination register
- mem_r31  out  1  registered link flag
- mem_size  out  2  decoded; valid-gated
- mem_se, mem_rw, mem_enable, mem_load, mem_rf_enable  out  1  decoded; valid-gated
- fwd_valid  out  1  equals mem_valid & mem_rf_enable & ~mem_load
- fwd_rd  out  RD_W  equals mem_rd
- fwd_data  out  DATA_W  mem_r31 ? mem_pc8 : mem_alu
- stall_cnt, bubble_cnt  out  CNT_W  performance counters

## Operation
Register update priority, evaluated each rising edge of clk:
- reset:
  - all registered outputs go to 0, including mem_valid, mem_ctrl, data, rd, r31 and both counters.
- flush (regardless of stall):
  - mem_valid <= 0 and mem_ctrl <= 0.
  - Data, rd and r31 registers hold their values (don't-care while invalid).
- stall:
  - all pipeline registers hold.
- otherwise (load):
  - every mem_* register takes its ex_* value;
  - mem_valid <= ex_valid.
  - When ex_valid = 0, mem_ctrl <= 0, so an invalid entry never carries control.

Decoded outputs:
- Combinational from the registers, ANDed with mem_valid. mem_size is 2'b00 when invalid.
- Bit selects use the POS_* parameters.

Forwarding tap:
- Combinational from the registers.
- Loads are excluded (their data is not available until the end of MEM).

Counters, lower priority than reset:
- cnt_clear: both counters go to 0. This overrides any increment in the same cycle.
- stall_cnt increments when stall = 1, flush = 0 and mem_valid = 1.
- bubble_cnt increments on every edge that loads an invalid entry: flush = 1, or (stall = 0 and ex_valid = 0).
- Both counters saturate at 2^CNT_W-1 and do not wrap.

## Timing
- Latency is one cycle: EX values presented before edge N appear on the mem_* outputs after edge N.
- stall and flush are sampled at the same edge as the data. No combinational path runs from stall/flush to any output.
- Stall may be held for any number of cycles. Outputs stay stable throughout, and the entry is not duplicated or lost.
- flush together with stall: the flush wins, and the entry is destroyed at that edge.
- Reset during a stall or flush:
  - all outputs are 0 after the edge;
  - there is no residual hold state;
  - the first edge with reset = 0 performs a normal update.
- Reset values: every output is 0. fwd_data = 0 and fwd_valid = 0.

## Test plan
- **Reset:** drive all inputs to 1s and assert reset for 2 cycles.
  - Required: every output = 0 after the first edge, and counters = 0.
- **Pass-through:** ex_valid = 1, ex_ctrl = 22'h000661 (rf_en = 1, load = 1, size = 2'b11, mem_en = 1), ex_alu = 32'h0000_1234, ex_rd = 5'd7, no stall or flush.
  - Required after one edge: mem_enable = 1, mem_size = 2'b11, mem_load = 1, mem_rd = 7, fwd_valid = 0 (load).
- **Stall hold:** load alu = 32'hAAAA_0001, then hold stall = 1 for 3 cycles while the ex_* inputs change.
  - Required: outputs stay 32'hAAAA_0001 and stall_cnt = 3.
  - After stall is released, the next ex value appears one edge later.
- **Flush with stall:** assert flush = 1 and stall = 1 while mem_valid = 1 and rf_en = 1.
  - Required: mem_valid = 0, mem_rf_enable = 0, fwd_valid = 0, bubble_cnt increments by 1 and stall_cnt does not.
- **R31 forward:** ex_r31 = 1, ex_pc8 = 32'h0040_0008, rf_en = 1, load = 0.
  - Required: fwd_data = 32'h0040_0008 and fwd_valid = 1.
  - With ex_r31 = 0, fwd_data = ex_alu.
- **Counter saturation:** CNT_W = 4, stall for 20 cycles.
  - Required: stall_cnt = 4'hF.
  - cnt_clear together with stall gives 0 on that edge.
